mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the datapath and bus width; the only legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, giving the bus address width.
REQ-003 SHALL have parameter REG_ADDR_W, default 5, giving the register-file address width.
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port valid_i  in  1  an instruction is present on the upstream inputs.
REQ-007 SHALL have port flush_i  in  1  discard the instruction in the stage.
REQ-008 SHALL have ports wd_i  in  REG_ADDR_W, wreg_i  in  1 and wdata_i  in  DATA_W carrying the upstream write-back target, enable and ALU result.
REQ-009 SHALL have port mem_op_i  in  4  memory operation: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 SB, 8 SH, 9 SW, 10 LD, 11 SD.
REQ-010 SHALL have port mem_addr_i  in  ADDR_W  effective byte address.
REQ-011 SHALL have port mem_sdata_i  in  DATA_W  store data, right-aligned.
REQ-012 SHALL have port stall_req_o  out  1  upstream hold request.
REQ-013 SHALL have ports bus_req_o  out  1, bus_we_o  out  1, bus_sel_o  out  DATA_W/8 (byte enables), bus_addr_o  out  ADDR_W (lane-aligned) and bus_wdata_o  out  DATA_W (lane-positioned).
REQ-014 SHALL have ports bus_ack_i  in  1 and bus_rdata_i  in  DATA_W carrying the bus response.
REQ-015 SHALL have ports wd_o  out  REG_ADDR_W, wreg_o  out  1 and wdata_o  out  DATA_W as registered write-back outputs.
REQ-016 SHALL have port exc_align_o  out  1  a registered one-cycle misalignment flag, coincident with the write-back outputs.

Function
REQ-017 SHALL implement FSM states IDLE and WAIT.
REQ-018 In IDLE, valid_i with mem_op_i NONE SHALL load wd_i/wreg_i/wdata_i into the write-back registers at the next edge (latency 1, no stall).
REQ-019 In IDLE, valid_i with an aligned memory op SHALL assert stall_req_o combinationally, register the bus address, byte enables, write data and write-enable, and go to WAIT.
REQ-020 In WAIT, bus_req_o SHALL be 1 and the bus outputs SHALL stay stable until the bus_ack_i cycle.
REQ-021 stall_req_o SHALL equal (IDLE and a valid aligned memory op) or (WAIT and not bus_ack_i), so it falls in the ack cycle.
REQ-022 On bus_ack_i in WAIT, the block SHALL return to IDLE and load the write-back registers at that edge: loads write the extracted and extended data, stores write wreg_o=0.
REQ-023 bus_ack_i while in IDLE SHALL be ignored.
REQ-024 Lane = mem_addr_i[log2(DATA_W/8)-1:0]; B/BU select one byte and H/HU two bytes; W/WU select four bytes, and D selects all eight bytes (DATA_W=64 only); signed loads sign-extend and unsigned loads zero-extend to DATA_W.
REQ-025 When DATA_W=32, ops LWU, LD and SD SHALL behave as NONE.
REQ-026 Misalignment (H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0) SHALL issue no bus access and no stall, and SHALL produce wreg_o=0 and exc_align_o=1 at the next edge.
REQ-027 flush_i in IDLE SHALL produce a bubble (wreg_o=0, no bus access).
REQ-028 flush_i in WAIT SHALL set a kill flag: the bus transaction still completes, and at ack the result SHALL be written with wreg_o=0.
REQ-029 valid_i=0 in IDLE SHALL produce wreg_o=0 and exc_align_o=0 at the next edge.

Reset
REQ-030 On rst=0, asynchronously: state IDLE, wd_o=0, wreg_o=0, wdata_o=0, exc_align_o=0, bus_req_o=0, bus_we_o=0, bus_sel_o=0, kill flag cleared; reset during WAIT SHALL abandon the transaction with no write-back.
REQ-031 stall_req_o SHALL be 0 throughout reset.

Structure
REQ-032 The mem_op encodings, the FSM state encoding and NOP_REG_ADDR SHALL live in the shared package mem_pkg.
REQ-033 Lane extraction and sign/zero extension SHALL be one combinational sub-module, mem_load_align.

Verification
REQ-034 ALU pass-through: op NONE, wd_i=5, wdata_i=0x1234 -> next cycle wd_o=5, wreg_o=1, wdata_o=0x1234, stall_req_o never 1.
REQ-035 LB at addr 0x103, bus_rdata_i=0x80FF_0000, ack after 3 WAIT cycles -> stall_req_o high for 3 cycles, wdata_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-036 SH at addr 0x102, mem_sdata_i=0xABCD -> bus_sel_o=4'b1100, bus_wdata_o=0xABCD0000, bus_we_o=1, wreg_o=0 after ack.
REQ-037 LW at addr 0x101 -> no bus_req_o, exc_align_o=1 for one cycle, wreg_o=0.
REQ-038 flush_i during WAIT, then ack -> wreg_o=0; rst=0 mid-WAIT -> bus_req_o=0 immediately and state IDLE.
REQ-039 With DATA_W=64, LD at 0x108 -> bus_sel_o=8'hFF; LW at 0x10C with rdata[63:32]=0x80000000 -> wdata_o=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: operation codes, FSM
// states, access sizes, the decoded-operation record and small helpers.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_LWU  = 4'd6,
        OP_SB   = 4'd7,
        OP_SH   = 4'd8,
        OP_SW   = 4'd9,
        OP_LD   = 4'd10,
        OP_SD   = 4'd11
    } mem_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef struct packed {
        logic      is_mem;
        logic      is_load;
        logic      is_signed;
        mem_size_e size;
    } mem_dec_t;

    // Register address written by bubbles and killed instructions.
    localparam int NOP_REG_ADDR = 0;

    // Decode an operation code; 64-bit-only ops decode as NONE on a 32-bit path.
    function automatic mem_dec_t decode_op(input logic [3:0] op, input logic wide);
        mem_dec_t d;
        d = '{is_mem: 1'b0, is_load: 1'b0, is_signed: 1'b0, size: SZ_B};
        case (op)
            OP_LB:  d = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: SZ_B};
            OP_LBU: d = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: SZ_B};
            OP_LH:  d = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: SZ_H};
            OP_LHU: d = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: SZ_H};
            OP_LW:  d = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: SZ_W};
            OP_LWU: if (wide) d = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: SZ_W};
            OP_SB:  d = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: SZ_B};
            OP_SH:  d = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: SZ_H};
            OP_SW:  d = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: SZ_W};
            OP_LD:  if (wide) d = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: SZ_D};
            OP_SD:  if (wide) d = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: SZ_D};
            default: ;
        endcase
        return d;
    endfunction

    // True when the low address bits are not a multiple of the access size.
    function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] a);
        logic m;
        m = 1'b0;
        case (size)
            SZ_H:    m = a[0];
            SZ_W:    m = |a[1:0];
            SZ_D:    m = |a;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: moves the addressed lane down to bit 0 and extends
// it to the full datapath width, signed or unsigned.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]             i_rdata,
    input  logic [$clog2(DATA_W/8)-1:0]   i_lane,
    input  mem_size_e                     i_size,
    input  logic                          i_signed,
    output logic [DATA_W-1:0]             o_data
);

    logic [DATA_W-1:0] w_shifted;
    logic signed [7:0]  w_b;
    logic signed [15:0] w_h;
    logic signed [31:0] w_w;

    assign w_shifted = i_rdata >> {i_lane, 3'b000};
    assign w_b       = w_shifted[7:0];
    assign w_h       = w_shifted[15:0];
    assign w_w       = w_shifted[31:0];

    // Select the access width and apply sign or zero extension.
    always_comb begin
        o_data = w_shifted;
        case (i_size)
            SZ_B:    o_data = i_signed ? DATA_W'(w_b) : DATA_W'(w_shifted[7:0]);
            SZ_H:    o_data = i_signed ? DATA_W'(w_h) : DATA_W'(w_shifted[15:0]);
            SZ_W:    o_data = i_signed ? DATA_W'(w_w) : DATA_W'(w_shifted[31:0]);
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage. ALU results pass straight through to the
// write-back registers; aligned loads/stores hold the pipeline while a
// single bus transaction runs, then write back the aligned load data.
// DATA_W must be 32 or 64.
module mem_access
    import mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic                   flush_i,
    input  logic [REG_ADDR_W-1:0]  wd_i,
    input  logic                   wreg_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [3:0]             mem_op_i,
    input  logic [ADDR_W-1:0]      mem_addr_i,
    input  logic [DATA_W-1:0]      mem_sdata_i,
    output logic                   stall_req_o,
    output logic                   bus_req_o,
    output logic                   bus_we_o,
    output logic [DATA_W/8-1:0]    bus_sel_o,
    output logic [ADDR_W-1:0]      bus_addr_o,
    output logic [DATA_W-1:0]      bus_wdata_o,
    input  logic                   bus_ack_i,
    input  logic [DATA_W-1:0]      bus_rdata_i,
    output logic [REG_ADDR_W-1:0]  wd_o,
    output logic                   wreg_o,
    output logic [DATA_W-1:0]      wdata_o,
    output logic                   exc_align_o
);

    localparam int   NB     = DATA_W / 8;
    localparam int   LANE_W = $clog2(NB);
    localparam logic WIDE   = (DATA_W == 64);

    // Control state
    state_e                r_state;
    logic                  r_bus_req;
    logic                  r_bus_we;
    logic [NB-1:0]         r_bus_sel;
    logic                  r_kill;
    logic                  r_wb_en;
    logic [REG_ADDR_W-1:0] r_wd;
    logic                  r_wreg;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_exc;

    // Transaction data captured at issue
    logic [ADDR_W-1:0]     r_bus_addr;
    logic [DATA_W-1:0]     r_bus_wdata;
    logic [REG_ADDR_W-1:0] r_ld_wd;
    logic [LANE_W-1:0]     r_ld_lane;
    mem_size_e             r_ld_size;
    logic                  r_ld_signed;
    logic                  r_is_load;

    mem_dec_t              w_dec;
    logic                  w_misalign;
    logic                  w_go;
    logic [LANE_W-1:0]     w_lane;
    logic [NB-1:0]         w_sel_base;
    logic [NB-1:0]         w_sel;
    logic [DATA_W-1:0]     w_sdata_m;
    logic [DATA_W-1:0]     w_bus_wdata;
    logic [ADDR_W-1:0]     w_bus_addr;
    logic [DATA_W-1:0]     w_ld_data;

    assign w_dec      = decode_op(mem_op_i, WIDE);
    assign w_misalign = w_dec.is_mem & is_misaligned(w_dec.size, mem_addr_i[2:0]);
    assign w_go       = valid_i & ~flush_i & w_dec.is_mem & ~w_misalign;
    assign w_lane     = mem_addr_i[LANE_W-1:0];
    assign w_bus_addr = {mem_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

    // Hold upstream while an access is being issued or awaiting its ack;
    // gated by reset so a valid instruction cannot raise it during reset.
    assign stall_req_o = rst & (((r_state == IDLE) & w_go) |
                                ((r_state == WAIT) & ~bus_ack_i));

    // Byte-enable pattern and store data trimmed to the access size.
    always_comb begin
        w_sel_base = '0;
        w_sdata_m  = mem_sdata_i;
        case (w_dec.size)
            SZ_B: begin
                w_sel_base = NB'(1'b1);
                w_sdata_m  = DATA_W'(mem_sdata_i[7:0]);
            end
            SZ_H: begin
                w_sel_base = NB'(2'b11);
                w_sdata_m  = DATA_W'(mem_sdata_i[15:0]);
            end
            SZ_W: begin
                w_sel_base = NB'(4'hF);
                w_sdata_m  = DATA_W'(mem_sdata_i[31:0]);
            end
            default: begin
                w_sel_base = '1;
                w_sdata_m  = mem_sdata_i;
            end
        endcase
    end

    assign w_sel       = w_sel_base << w_lane;
    assign w_bus_wdata = w_sdata_m << {w_lane, 3'b000};

    mem_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .i_rdata  (bus_rdata_i),
        .i_lane   (r_ld_lane),
        .i_size   (r_ld_size),
        .i_signed (r_ld_signed),
        .o_data   (w_ld_data)
    );

    // Capture address, store data and load shaping when an access is issued.
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && w_go) begin
            r_bus_addr  <= w_bus_addr;
            r_bus_wdata <= w_bus_wdata;
            r_ld_wd     <= wd_i;
            r_ld_lane   <= w_lane;
            r_ld_size   <= w_dec.size;
            r_ld_signed <= w_dec.is_signed;
            r_is_load   <= w_dec.is_load;
        end
    end

    // Stage FSM: pass-through and issue in IDLE, completion on ack in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_bus_sel <= '0;
            r_kill    <= 1'b0;
            r_wb_en   <= 1'b0;
            r_wd      <= '0;
            r_wreg    <= 1'b0;
            r_wdata   <= '0;
            r_exc     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wreg <= 1'b0;
                    r_exc  <= 1'b0;
                    if (valid_i && !flush_i) begin
                        if (!w_dec.is_mem) begin
                            r_wd    <= wd_i;
                            r_wreg  <= wreg_i;
                            r_wdata <= wdata_i;
                        end else if (w_misalign) begin
                            r_wd  <= REG_ADDR_W'(NOP_REG_ADDR);
                            r_exc <= 1'b1;
                        end else begin
                            r_state   <= WAIT;
                            r_bus_req <= 1'b1;
                            r_bus_we  <= ~w_dec.is_load;
                            r_bus_sel <= w_sel;
                            r_kill    <= 1'b0;
                            r_wb_en   <= w_dec.is_load & wreg_i;
                        end
                    end else begin
                        r_wd <= REG_ADDR_W'(NOP_REG_ADDR);
                    end
                end
                WAIT: begin
                    r_wreg <= 1'b0;
                    r_exc  <= 1'b0;
                    if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                    if (bus_ack_i) begin
                        r_state   <= IDLE;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_bus_sel <= '0;
                        r_kill    <= 1'b0;
                        r_wd      <= r_ld_wd;
                        r_wreg    <= r_wb_en & ~r_kill & ~flush_i;
                        if (r_is_load) begin
                            r_wdata <= w_ld_data;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_sel_o   = r_bus_sel;
    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;
    assign wd_o        = r_wd;
    assign wreg_o      = r_wreg;
    assign wdata_o     = r_wdata;
    assign exc_align_o = r_exc;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a 32-bit and a 64-bit instance share the
// stimulus bus; each has its own valid so only the selected one acts.
module tb_mem_access;
    import mem_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, v32, v64, flush, wreg, ack;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [4:0]  wd;
    logic [63:0] wdata, sdata, rdata;

    logic        s32, breq32, bwe32, wrego32, exc32;
    logic [3:0]  sel32;
    logic [31:0] badr32, bwd32, wdo32;
    logic [4:0]  wdo_a32;

    logic        s64, breq64, bwe64, wrego64, exc64;
    logic [7:0]  sel64;
    logic [31:0] badr64;
    logic [63:0] bwd64, wdo64;
    logic [4:0]  wdo_a64;

    mem_access #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .valid_i(v32), .flush_i(flush),
        .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata[31:0]),
        .mem_op_i(op), .mem_addr_i(addr), .mem_sdata_i(sdata[31:0]),
        .stall_req_o(s32), .bus_req_o(breq32), .bus_we_o(bwe32),
        .bus_sel_o(sel32), .bus_addr_o(badr32), .bus_wdata_o(bwd32),
        .bus_ack_i(ack), .bus_rdata_i(rdata[31:0]),
        .wd_o(wdo_a32), .wreg_o(wrego32), .wdata_o(wdo32), .exc_align_o(exc32)
    );

    mem_access #(.DATA_W(64), .ADDR_W(32), .REG_ADDR_W(5)) u_dut64 (
        .clk(clk), .rst(rst), .valid_i(v64), .flush_i(flush),
        .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata),
        .mem_op_i(op), .mem_addr_i(addr), .mem_sdata_i(sdata),
        .stall_req_o(s64), .bus_req_o(breq64), .bus_we_o(bwe64),
        .bus_sel_o(sel64), .bus_addr_o(badr64), .bus_wdata_o(bwd64),
        .bus_ack_i(ack), .bus_rdata_i(rdata),
        .wd_o(wdo_a64), .wreg_o(wrego64), .wdata_o(wdo64), .exc_align_o(exc64)
    );

    // Observed outputs of whichever instance is under test
    bit          cur64 = 1'b0;
    logic        o_stall, o_breq, o_we, o_wreg, o_exc;
    logic [7:0]  o_sel;
    logic [31:0] o_addr;
    logic [63:0] o_bwd, o_wdata;
    logic [4:0]  o_wd;

    always_comb begin
        if (cur64) begin
            o_stall = s64;  o_breq = breq64; o_we = bwe64; o_wreg = wrego64; o_exc = exc64;
            o_sel = sel64;  o_addr = badr64; o_bwd = bwd64; o_wdata = wdo64; o_wd = wdo_a64;
        end else begin
            o_stall = s32;  o_breq = breq32; o_we = bwe32; o_wreg = wrego32; o_exc = exc32;
            o_sel = {4'h0, sel32}; o_addr = badr32; o_bwd = {32'h0, bwd32};
            o_wdata = {32'h0, wdo32}; o_wd = wdo_a32;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bus signals captured in the ack cycle of the last transaction
    logic        c_req, c_we;
    logic [7:0]  c_sel;
    logic [31:0] c_addr;
    logic [63:0] c_bwd;
    int          stalls;

    // One bus transaction: issue, nwait cycles in WAIT without ack, then ack.
    // Returns at the negedge after the ack edge, with write-back visible.
    task automatic txn(input logic [3:0] o, input logic [31:0] a,
                       input logic [63:0] sd, input logic [63:0] rd,
                       input int nwait, input bit do_flush);
        @(negedge clk);
        op = o; addr = a; sdata = sd; wd = 5'd7; wreg = 1'b1; wdata = 64'hDEAD;
        if (cur64) v64 = 1'b1; else v32 = 1'b1;
        stalls = 0;
        if (o_stall) stalls++;
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            flush = do_flush && (i == 0);
            if (o_stall) stalls++;
        end
        @(negedge clk);
        flush = 1'b0; ack = 1'b1; rdata = rd;
        if (o_stall) stalls++;
        c_req = o_breq; c_we = o_we; c_sel = o_sel; c_addr = o_addr; c_bwd = o_bwd;
        @(negedge clk);
        ack = 1'b0; v32 = 1'b0; v64 = 1'b0;
    endtask

    initial begin
        rst = 1'b0; v32 = 1'b1; v64 = 1'b0; flush = 1'b0; wreg = 1'b0; ack = 1'b0;
        op = OP_LW; addr = 32'h100; wd = '0; wdata = '0; sdata = '0; rdata = '0;
        #1;
        check("rst_stall", o_stall, 0);
        repeat (2) @(negedge clk);
        check("rst_stall_hold", o_stall, 0);
        check("rst_breq", o_breq, 0);
        check("rst_sel", o_sel, 0);
        check("rst_wreg", o_wreg, 0);
        check("rst_wdata", o_wdata, 0);
        check("rst_wd", o_wd, 0);
        check("rst_exc", o_exc, 0);
        v32 = 1'b0;
        rst = 1'b1;

        // ALU pass-through
        @(negedge clk);
        v32 = 1'b1; op = OP_NONE; wd = 5'd5; wreg = 1'b1; wdata = 64'h1234;
        check("alu_stall", o_stall, 0);
        @(negedge clk);
        v32 = 1'b0;
        check("alu_wd", o_wd, 5);
        check("alu_wreg", o_wreg, 1);
        check("alu_wdata", o_wdata, 64'h1234);
        @(negedge clk);
        check("idle_wreg", o_wreg, 0);
        check("idle_exc", o_exc, 0);

        // Loads, 32-bit
        txn(OP_LB, 32'h103, 64'h0, 64'h80FF_0000, 2, 1'b0);
        check("lb_stalls", stalls, 3);
        check("lb_req", c_req, 1);
        check("lb_sel", c_sel, 8'h08);
        check("lb_addr", c_addr, 32'h100);
        check("lb_we", c_we, 0);
        check("lb_wdata", o_wdata, 64'hFFFF_FF80);
        check("lb_wreg", o_wreg, 1);
        check("lb_wd", o_wd, 7);
        txn(OP_LBU, 32'h103, 64'h0, 64'h80FF_0000, 2, 1'b0);
        check("lbu_wdata", o_wdata, 64'h0000_0080);
        txn(OP_LH, 32'h102, 64'h0, 64'hF00D_1234, 0, 1'b0);
        check("lh_stalls", stalls, 1);
        check("lh_wdata", o_wdata, 64'hFFFF_F00D);
        txn(OP_LHU, 32'h102, 64'h0, 64'hF00D_1234, 1, 1'b0);
        check("lhu_wdata", o_wdata, 64'h0000_F00D);
        txn(OP_LW, 32'h104, 64'h0, 64'h89AB_CDEF, 1, 1'b0);
        check("lw_wdata", o_wdata, 64'h89AB_CDEF);
        check("lw_sel", c_sel, 8'h0F);
        check("lw_addr", c_addr, 32'h104);

        // Stores
        txn(OP_SH, 32'h102, 64'h1234_ABCD, 64'h0, 1, 1'b0);
        check("sh_sel", c_sel, 8'h0C);
        check("sh_bwd", c_bwd, 64'hABCD_0000);
        check("sh_we", c_we, 1);
        check("sh_wreg", o_wreg, 0);
        txn(OP_SB, 32'h101, 64'h0000_005A, 64'h0, 1, 1'b0);
        check("sb_sel", c_sel, 8'h02);
        check("sb_bwd", c_bwd, 64'h0000_5A00);

        // Misaligned word
        @(negedge clk);
        v32 = 1'b1; op = OP_LW; addr = 32'h101; wreg = 1'b1;
        check("mis_stall", o_stall, 0);
        @(negedge clk);
        v32 = 1'b0;
        check("mis_exc", o_exc, 1);
        check("mis_wreg", o_wreg, 0);
        check("mis_breq", o_breq, 0);
        @(negedge clk);
        check("mis_exc_clr", o_exc, 0);

        // 64-bit-only op on a 32-bit path acts as NONE
        @(negedge clk);
        v32 = 1'b1; op = OP_LWU; addr = 32'h100; wd = 5'd9; wreg = 1'b1; wdata = 64'h77;
        check("lwu32_stall", o_stall, 0);
        @(negedge clk);
        v32 = 1'b0;
        check("lwu32_wd", o_wd, 9);
        check("lwu32_wreg", o_wreg, 1);
        check("lwu32_wdata", o_wdata, 64'h77);

        // Flush in IDLE
        @(negedge clk);
        v32 = 1'b1; flush = 1'b1; op = OP_LB; addr = 32'h100;
        check("fl_idle_stall", o_stall, 0);
        @(negedge clk);
        v32 = 1'b0; flush = 1'b0;
        check("fl_idle_breq", o_breq, 0);
        check("fl_idle_wreg", o_wreg, 0);

        // Ack while idle is ignored
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ack_idle_breq", o_breq, 0);
        check("ack_idle_wreg", o_wreg, 0);

        // Flush during WAIT kills the write-back
        txn(OP_LW, 32'h100, 64'h0, 64'h1111_2222, 2, 1'b1);
        check("fl_wait_req", c_req, 1);
        check("fl_wait_wreg", o_wreg, 0);

        // Reset mid-WAIT
        @(negedge clk);
        v32 = 1'b1; op = OP_LB; addr = 32'h100; wreg = 1'b1;
        @(negedge clk);
        check("rw_breq_before", o_breq, 1);
        rst = 1'b0;
        #1;
        check("rw_breq", o_breq, 0);
        check("rw_stall", o_stall, 0);
        v32 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rw_wreg", o_wreg, 0);
        v32 = 1'b1; op = OP_NONE; wd = 5'd3; wreg = 1'b1; wdata = 64'h55;
        check("rw_idle_stall", o_stall, 0);
        @(negedge clk);
        v32 = 1'b0;
        check("rw_idle_wd", o_wd, 3);
        check("rw_idle_wdata", o_wdata, 64'h55);

        // 64-bit datapath
        cur64 = 1'b1;
        txn(OP_LD, 32'h108, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 1'b0);
        check("ld64_sel", c_sel, 8'hFF);
        check("ld64_addr", c_addr, 32'h108);
        check("ld64_wdata", o_wdata, 64'h0123_4567_89AB_CDEF);
        txn(OP_LW, 32'h10C, 64'h0, 64'h8000_0000_1234_5678, 1, 1'b0);
        check("lw64_sel", c_sel, 8'hF0);
        check("lw64_addr", c_addr, 32'h108);
        check("lw64_wdata", o_wdata, 64'hFFFF_FFFF_8000_0000);
        txn(OP_LWU, 32'h10C, 64'h0, 64'h8000_0000_1234_5678, 1, 1'b0);
        check("lwu64_wdata", o_wdata, 64'h0000_0000_8000_0000);
        txn(OP_SD, 32'h108, 64'hCAFE_F00D_1234_5678, 64'h0, 1, 1'b0);
        check("sd64_bwd", c_bwd, 64'hCAFE_F00D_1234_5678);
        check("sd64_sel", c_sel, 8'hFF);
        check("sd64_wreg", o_wreg, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
